reciprocal_nr_pipe: RTL and testbench
=====================================

// Module: reciprocal_nr_pipe
// PURPOSE
//  Parametrised Newton-Raphson reciprocal unit for the Gauss-Seidel solver: 1/d for a signed integer divisor.
//  Produces a signed fixed-point S1.FRAC_W quotient.
//  Uses a valid/ready handshake on both sides, latches the operand on accept, and flags divide-by-zero.
//  Sits between the coefficient loader and the update datapath.
// PARAMETERS
//  IN_W      8   divisor width, two's complement
//  FRAC_W    30  quotient fraction bits; OUT_W = FRAC_W+2 (S1.FRAC_W)
//  NR_ITERS  5   Newton-Raphson iterations, 1..15
// PORTS
//  i_clk       in   1       clock, rising edge
//  i_rst_n     in   1       asynchronous active-low reset
//  i_valid     in   1       divisor valid
//  o_ready     out  1       unit can accept; transfer when i_valid & o_ready
//  i_divisor   in   IN_W    signed divisor
//  o_valid     out  1       result valid; held until i_ready
//  i_ready     in   1       consumer accepts the result
//  o_quotient  out  OUT_W   S1.FRAC_W reciprocal
//  o_div_zero  out  1       divisor was 0; qualified by o_valid
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; o_valid=0, o_quotient=0, o_div_zero=0, iteration counter=0.
//   - o_ready=1 once the state is IDLE.
//   - Reset asserted mid-iteration aborts the operation; no result is produced.
//  o_ready = (state==IDLE) | (state==DONE & i_ready); back-to-back accept is allowed.
//  On accept, the divisor is registered; i_divisor is ignored afterwards.
//  FSM states: IDLE, NORM, MUL1, MUL2, DONE.
//   IDLE -> NORM on accept.
//   NORM: compute mag=|d| as IN_W-bit unsigned (-2^(IN_W-1) is handled), z=floor(log2 mag), pow2 flag.
//    - d==0: result = {0,1...1} (max positive), o_div_zero=1 -> DONE.
//    - pow2: x = 2^-z exact -> DONE.
//    - else: x0 = 2^-(z+1) in U1.FRAC_W, cnt=0 -> MUL1.
//   MUL1: t = mag*x, truncated to U2.FRAC_W, registered -> MUL2.
//   MUL2: x = ((2.0 - t) * x) >> FRAC_W, truncated; cnt++.
//    -> DONE when cnt==NR_ITERS-1 (before increment), else -> MUL1.
//   DONE: o_valid=1; if i_ready: -> NORM when i_valid is also high (new accept), else -> IDLE.
//  Output sign: o_quotient = d<0 ? -x (two's complement, OUT_W) : x.
//   Registered on the NORM/MUL2 -> DONE transition; stable while o_valid & !i_ready.
//  Latency (accept edge = cycle k):
//   - zero/pow2: o_valid at k+2.
//   - general: o_valid at k+2+2*NR_ITERS (k+12 for defaults).
//  Accuracy: iteration from below; with defaults, |o_quotient - exact| <= 4 LSB, and result <= exact magnitude.
//  Widths: mag*x needs IN_W+FRAC_W+1 bits; (2-t)*x needs 2*FRAC_W+3 bits; intermediates never overflow.
// STRUCTURE
//  Package recip_pkg:
//   - state encoding (3-bit localparams);
//   - OUT_W derivation;
//   - fixed-point constants ONE = 1<<FRAC_W, TWO = 2<<FRAC_W;
//   - default NR_ITERS.
//  Sub-module lead_one_enc #(IN_W):
//   - combinational priority encoder, mag -> z[$clog2(IN_W)-1:0], pow2, zero;
//   - reused by the normaliser in the solver.
//  Top: FSM, iteration datapath (one shared multiplier per stage), output register and negation.
// TESTING (defaults: IN_W=8, FRAC_W=30, NR_ITERS=5)
//  1. d=4, i_ready=1 -> o_quotient=0x1000_0000, o_div_zero=0; o_valid at k+2 for one cycle.
//  2. d=-128 -> 0xFF80_0000; d=-1 -> 0xC000_0000; d=1 -> 0x4000_0000; all at k+2.
//  3. d=3 -> 0x1555_5555 within -4..0 LSB, o_valid at k+12; d=-7 -> negated 0x0924_9249, within 4 LSB.
//  4. d=0 -> o_quotient=0x7FFF_FFFF, o_div_zero=1 at k+2; next op d=5 clears o_div_zero.
//  5. Backpressure: d=5 with i_ready=0 for 6 cycles after o_valid -> o_valid and o_quotient held, o_ready=0;
//     i_ready=1 with i_valid=1 (d=2) -> d=2 accepted the same cycle, 0x2000_0000 two cycles later.
//  6. i_rst_n pulsed low during MUL1 of d=3 -> outputs 0 immediately, o_ready=1 after release;
//     next d=6 returns ~0x0AAA_AAAA, with no stale result.

Source files
------------

// File: rtl/recip_pkg.sv
// Shared definitions for the Newton-Raphson reciprocal unit.
// Holds the FSM state encoding, default parameters, the S1.FRAC_W output
// width derivation and a helper for building fixed-point integer constants.
package recip_pkg;

  localparam int unsigned DEF_IN_W     = 8;
  localparam int unsigned DEF_FRAC_W   = 30;
  localparam int unsigned DEF_NR_ITERS = 5;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ENC_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ENC_NORM = 3'd1;
  localparam logic [ST_W-1:0] ENC_MUL1 = 3'd2;
  localparam logic [ST_W-1:0] ENC_MUL2 = 3'd3;
  localparam logic [ST_W-1:0] ENC_DONE = 3'd4;

  typedef enum logic [ST_W-1:0] {
    IDLE = ENC_IDLE,
    NORM = ENC_NORM,
    MUL1 = ENC_MUL1,
    MUL2 = ENC_MUL2,
    DONE = ENC_DONE
  } state_e;

  // Signed quotient is S1.FRAC_W: sign bit, one integer bit, FRAC_W fraction bits.
  function automatic int unsigned out_width(input int unsigned frac_w);
    return frac_w + 2;
  endfunction

  // Integer value ipart expressed with frac_w fraction bits (ONE = 1<<FRAC_W, TWO = 2<<FRAC_W).
  function automatic logic [63:0] fx_const(input int unsigned ipart, input int unsigned frac_w);
    return 64'(ipart) << frac_w;
  endfunction

endpackage

// File: rtl/lead_one_enc.sv
// Combinational leading-one encoder for an unsigned magnitude.
// Ports:
//   i_mag   in   IN_W  unsigned magnitude
//   o_z     out  ZW    floor(log2(i_mag)); 0 when i_mag is 0
//   o_pow2  out  1     i_mag is an exact non-zero power of two
//   o_zero  out  1     i_mag is zero
module lead_one_enc #(
  parameter  int unsigned IN_W = 8,
  localparam int unsigned ZW   = (IN_W > 1) ? $clog2(IN_W) : 1
) (
  input  logic [IN_W-1:0] i_mag,
  output logic [ZW-1:0]   o_z,
  output logic            o_pow2,
  output logic            o_zero
);

  // Highest set bit wins: later iterations overwrite earlier ones.
  always_comb begin
    o_z = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (i_mag[i]) begin
        o_z = ZW'(i);
      end
    end
  end

  assign o_zero = (i_mag == '0);
  // A power of two has a single set bit, so clearing the lowest one leaves nothing.
  assign o_pow2 = !o_zero && ((i_mag & (i_mag - IN_W'(1))) == '0);

endmodule

// File: rtl/reciprocal_nr_pipe.sv
// Newton-Raphson reciprocal unit: returns 1/d as a signed S1.FRAC_W value for
// a signed IN_W-bit divisor, with valid/ready handshakes on both sides.
// Ports:
//   i_clk       in   1      clock, rising edge
//   i_rst_n     in   1      asynchronous active-low reset
//   i_valid     in   1      divisor valid
//   o_ready     out  1      unit can accept (transfer on i_valid & o_ready)
//   i_divisor   in   IN_W   signed divisor, captured on accept
//   o_valid     out  1      result valid, held until i_ready
//   i_ready     in   1      consumer accepts the result
//   o_quotient  out  OUT_W  S1.FRAC_W reciprocal
//   o_div_zero  out  1      divisor was zero (qualified by o_valid)
module reciprocal_nr_pipe
  import recip_pkg::*;
#(
  parameter  int unsigned IN_W     = DEF_IN_W,
  parameter  int unsigned FRAC_W   = DEF_FRAC_W,
  parameter  int unsigned NR_ITERS = DEF_NR_ITERS,
  localparam int unsigned OUT_W    = out_width(FRAC_W)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [IN_W-1:0]  i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_quotient,
  output logic             o_div_zero
);

  localparam int unsigned XW  = FRAC_W + 1;           // iterate x, U1.FRAC_W
  localparam int unsigned TW  = FRAC_W + 2;           // t = mag*x, U2.FRAC_W
  localparam int unsigned P1W = IN_W + FRAC_W + 1;    // mag*x product
  localparam int unsigned P2W = 2 * FRAC_W + 3;       // (2-t)*x product
  localparam int unsigned ZW  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned CW  = 4;                    // holds NR_ITERS-1 up to 14

  localparam logic [XW-1:0]    X_ONE    = XW'(fx_const(1, FRAC_W));
  localparam logic [XW-1:0]    X_HALF   = X_ONE >> 1;
  localparam logic [TW-1:0]    T_TWO    = TW'(fx_const(2, FRAC_W));
  localparam logic [OUT_W-1:0] Q_MAX    = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(NR_ITERS - 1);

  state_e            r_state;
  state_e            w_next_state;

  logic [IN_W-1:0]   r_div;
  logic [IN_W-1:0]   w_mag;
  logic              w_neg;
  logic              w_ready;
  logic              w_accept;

  logic [ZW-1:0]     w_z;
  logic              w_pow2;
  logic              w_zero;

  logic [XW-1:0]     r_x;
  logic [XW-1:0]     w_x_pow2;
  logic [XW-1:0]     w_x_seed;
  logic [XW-1:0]     w_x_next;
  logic [TW-1:0]     r_t;
  logic [TW-1:0]     w_t;
  logic [TW-1:0]     w_two_minus_t;
  logic [CW-1:0]     r_cnt;

  logic              r_valid;
  logic [OUT_W-1:0]  r_quotient;
  logic              r_div_zero;

  // Zero-extend the unsigned iterate and apply the divisor sign.
  function automatic logic [OUT_W-1:0] apply_sign(input logic [XW-1:0] x, input logic neg);
    logic [OUT_W-1:0] ext;
    ext = OUT_W'(x);
    return neg ? (~ext + OUT_W'(1)) : ext;
  endfunction

  // Handshake: a finishing result frees the unit in the same cycle it is taken.
  assign w_ready  = (r_state == IDLE) || ((r_state == DONE) && i_ready);
  assign w_accept = i_valid && w_ready;

  // |d| in IN_W unsigned bits; the most negative divisor maps to 2^(IN_W-1).
  assign w_neg = r_div[IN_W-1];
  assign w_mag = w_neg ? (~r_div + IN_W'(1)) : r_div;

  lead_one_enc #(
    .IN_W (IN_W)
  ) u_lead_one_enc (
    .i_mag  (w_mag),
    .o_z    (w_z),
    .o_pow2 (w_pow2),
    .o_zero (w_zero)
  );

  // Exact result for powers of two, and the below-target seed 2^-(z+1) otherwise.
  assign w_x_pow2 = X_ONE >> w_z;
  assign w_x_seed = X_HALF >> w_z;

  // Iteration datapath: mag*x is exact on the FRAC_W grid, only leading zeros are dropped.
  assign w_t           = TW'(P1W'(w_mag) * P1W'(r_x));
  assign w_two_minus_t = T_TWO - r_t;
  // Truncation keeps every iterate at or below 1/mag.
  assign w_x_next      = XW'((P2W'(w_two_minus_t) * P2W'(r_x)) >> FRAC_W);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = NORM;
        end
      end
      NORM: begin
        if (w_zero || w_pow2) begin
          w_next_state = DONE;
        end else begin
          w_next_state = MUL1;
        end
      end
      MUL1: begin
        w_next_state = MUL2;
      end
      MUL2: begin
        if (r_cnt == LAST_CNT) begin
          w_next_state = DONE;
        end else begin
          w_next_state = MUL1;
        end
      end
      DONE: begin
        if (i_ready) begin
          w_next_state = i_valid ? NORM : IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand capture and Newton-Raphson iteration registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
      r_x   <= '0;
      r_t   <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_div <= i_divisor;
      end
      case (r_state)
        NORM: begin
          r_cnt <= '0;
          r_x   <= w_pow2 ? w_x_pow2 : w_x_seed;
        end
        MUL1: begin
          r_t <= w_t;
        end
        MUL2: begin
          r_x   <= w_x_next;
          r_cnt <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: loaded only when entering DONE, so they hold under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_quotient <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_valid <= (w_next_state == DONE);
      if ((r_state == NORM) && (w_next_state == DONE)) begin
        if (w_zero) begin
          r_quotient <= Q_MAX;
          r_div_zero <= 1'b1;
        end else begin
          r_quotient <= apply_sign(w_x_pow2, w_neg);
          r_div_zero <= 1'b0;
        end
      end else if ((r_state == MUL2) && (w_next_state == DONE)) begin
        r_quotient <= apply_sign(w_x_next, w_neg);
        r_div_zero <= 1'b0;
      end
    end
  end

  assign o_ready    = w_ready;
  assign o_valid    = r_valid;
  assign o_quotient = r_quotient;
  assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_reciprocal_nr_pipe.sv
// Scoreboard bench for reciprocal_nr_pipe: the driver pushes the expected
// reciprocal (from integer division) per accepted divisor; a negedge monitor
// checks latency, value, hold behaviour and one-cycle valid pulses.
module tb_reciprocal_nr_pipe;

  localparam int unsigned IN_W     = 8;
  localparam int unsigned FRAC_W   = 30;
  localparam int unsigned NR_ITERS = 5;
  localparam int unsigned OUT_W    = FRAC_W + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [IN_W-1:0]  i_divisor = '0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [OUT_W-1:0] o_quotient;
  logic             o_div_zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [IN_W-1:0] d;
    longint          ref_mag;   // floor(2^FRAC_W / |d|), or max positive for d==0
    bit              neg;
    int              tol;       // allowed shortfall in LSB below ref_mag
    bit              dz;
    int              lat;       // edges from accept edge to first o_valid sample
    int              acc_cyc;
  } exp_t;

  exp_t sb[$];

  reciprocal_nr_pipe #(
    .IN_W     (IN_W),
    .FRAC_W   (FRAC_W),
    .NR_ITERS (NR_ITERS)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_divisor  (i_divisor),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_quotient (o_quotient),
    .o_div_zero (o_div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // Reference: real reciprocal via integer division; exact cases finish early.
  function automatic exp_t model(input logic [IN_W-1:0] d, input int acc);
    exp_t   e;
    longint sd;
    longint mag;
    sd = longint'($signed(d));
    mag = (sd < 0) ? -sd : sd;
    e.d = d;
    e.acc_cyc = acc;
    if (mag == 0) begin
      e.dz = 1'b1;
      e.neg = 1'b0;
      e.ref_mag = (longint'(1) <<< (OUT_W - 1)) - 1;
      e.tol = 0;
      e.lat = 1;
    end else begin
      e.dz = 1'b0;
      e.neg = (sd < 0);
      e.ref_mag = (longint'(1) <<< FRAC_W) / mag;
      if (e.ref_mag * mag == (longint'(1) <<< FRAC_W)) begin
        e.tol = 0;
        e.lat = 1;
      end else begin
        e.tol = 4;
        e.lat = 1 + 2 * NR_ITERS;
      end
    end
    return e;
  endfunction

  function automatic bit value_ok(input exp_t e, input logic [OUT_W-1:0] q, input logic dz);
    longint gs;
    longint gm;
    gs = longint'($signed(q));
    if (e.dz) return dz && (longint'(q) == e.ref_mag);
    if (dz) return 1'b0;
    if (e.neg) begin
      if (gs >= 0) return 1'b0;
      gm = -gs;
    end else begin
      if (gs < 0) return 1'b0;
      gm = gs;
    end
    return (gm <= e.ref_mag) && (gm >= e.ref_mag - longint'(e.tol));
  endfunction

  // Monitor.
  bit               seen = 1'b0;
  bit               prev_hs = 1'b0;
  logic [OUT_W-1:0] first_q;
  logic             first_dz;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) chk(!o_valid, $sformatf("valid_pulse: o_valid=%0b after handshake, required 0", o_valid));
      if (o_valid) begin
        chk(sb.size() != 0, $sformatf("spurious: o_valid with no outstanding request, q=0x%08h", o_quotient));
        if (sb.size() != 0) begin
          e = sb[0];
          if (!seen) begin
            chk(cyc - e.acc_cyc == e.lat, $sformatf("latency d=%0d: got %0d edges, required %0d",
                $signed(e.d), cyc - e.acc_cyc, e.lat));
            chk(value_ok(e, o_quotient, o_div_zero), $sformatf(
                "value d=%0d: got q=0x%08h dz=%0b, required magnitude %0d-%0d..%0d neg=%0b dz=%0b",
                $signed(e.d), o_quotient, o_div_zero, e.ref_mag, e.tol, e.ref_mag, e.neg, e.dz));
            first_q = o_quotient;
            first_dz = o_div_zero;
            seen = 1'b1;
          end else begin
            chk(o_quotient == first_q && o_div_zero == first_dz, $sformatf(
                "hold d=%0d: got q=0x%08h dz=%0b, required 0x%08h dz=%0b",
                $signed(e.d), o_quotient, o_div_zero, first_q, first_dz));
          end
          if (!i_ready) begin
            chk(!o_ready, $sformatf("ready_hold d=%0d: got o_ready=%0b, required 0", $signed(e.d), o_ready));
          end else begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
      prev_hs = o_valid && i_ready;
    end
  end

  function automatic bit rdy(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic drive_cycle(input bit v, input logic [IN_W-1:0] d, input bit r, output bit acc);
    @(posedge clk);
    #1;
    i_valid = v;
    i_divisor = d;
    i_ready = r;
    @(negedge clk);
    acc = v && o_ready;
    if (acc) sb.push_back(model(d, cyc + 1));
  endtask

  task automatic send(input logic [IN_W-1:0] d, input int rmode, output int tries);
    bit acc;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      drive_cycle(1'b1, d, rdy(rmode), acc);
      tries++;
    end
    if (!acc) chk(1'b0, $sformatf("accept_timeout d=%0d: not accepted within %0d cycles", $signed(d), tries));
  endtask

  task automatic idle(input int n, input int rmode);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, IN_W'($urandom), rdy(rmode), acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      idle(1, 1);
      n++;
    end
    chk(sb.size() == 0, $sformatf("drain: %0d results outstanding, required 0", sb.size()));
    idle(1, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int t;
    int n;
    @(negedge clk);
    chk(!o_valid && o_quotient == '0 && !o_div_zero && o_ready, $sformatf(
        "reset_state: got valid=%0b q=0x%08h dz=%0b ready=%0b, required 0/0/0/1",
        o_valid, o_quotient, o_div_zero, o_ready));
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1);

    // Exact powers of two and the most negative divisor.
    send(8'sd4, 1, t);    drain();
    send(-8'sd128, 1, t); drain();
    send(-8'sd1, 1, t);   drain();
    send(8'sd1, 1, t);    drain();

    // General iteration, both signs.
    send(8'sd3, 1, t);    drain();
    send(-8'sd7, 1, t);   drain();

    // Divide by zero, then a normal op clears the flag.
    send(8'sd0, 1, t);    drain();
    send(8'sd5, 1, t);    drain();

    // Backpressure, then accept a new operand as the held result is taken.
    send(8'sd5, 0, t);
    n = 0;
    while (!o_valid && n < 40) begin
      idle(1, 0);
      n++;
    end
    chk(o_valid, "bp_wait: o_valid=0 after 40 cycles, required 1");
    idle(6, 0);
    send(8'sd2, 1, t);
    chk(t == 1, $sformatf("b2b_accept: took %0d cycles, required 1", t));
    drain();

    // Reset during MUL1 aborts the operation.
    send(8'sd3, 1, t);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    i_valid = 1'b0;
    sb.delete();
    #1;
    chk(!o_valid && o_quotient == '0 && !o_div_zero && o_ready, $sformatf(
        "abort_reset: got valid=%0b q=0x%08h dz=%0b ready=%0b, required 0/0/0/1",
        o_valid, o_quotient, o_div_zero, o_ready));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, 1);
    send(8'sd6, 1, t);    drain();

    // Random divisors with random consumer backpressure and gaps.
    for (int k = 0; k < 60; k++) begin
      send(IN_W'($urandom), 2, t);
      idle($urandom_range(0, 2), 2);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
